// File: rtl/div_operand_dispatch.sv
`default_nettype none
// ============================================================================
// Module      : div_operand_dispatch
// Description : Operand dispatch stage in front of the bfloat16 divider.
//               Queues (a,b) pairs in a small FIFO and presents them one at a
//               time on the divider's STB/BUSY handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module div_operand_dispatch #(
    parameter int DEPTH = 4,
    parameter int AW    = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [15:0]      req_a,
    input  logic [15:0]      req_b,
    output logic [15:0]      input_a,
    output logic [15:0]      input_b,
    output logic             div_input_STB,
    input  logic             div_BUSY,
    output logic [AW:0]      fifo_level,
    output logic [CNT_W-1:0] issue_count,
    output logic [CNT_W-1:0] stall_cycles,
    output logic             dispatch_idle
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PRESENT  = 2'd1,
        ST_WAIT_ACK = 2'd2
    } state_t;

    localparam logic [AW:0]      C_DEPTH   = (AW+1)'(DEPTH);
    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

    // FIFO storage: {a, b} per entry
    logic [31:0]      mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;

    state_t           state_q, state_d;
    logic [15:0]      a_q, a_d;
    logic [15:0]      b_q, b_d;
    logic             stb_q, stb_d;
    logic [CNT_W-1:0] issue_q, issue_d;
    logic [CNT_W-1:0] stall_q, stall_d;

    logic             w_full;
    logic             w_push;
    logic             w_pop;
    logic [31:0]      w_head;

    // A full FIFO never accepts, even when the head pops on the same edge.
    assign w_full    = (level_q == C_DEPTH);
    assign req_ready = !w_full && !flush;
    assign w_push    = req_valid && req_ready;
    // The presented pair leaves the queue only once the divider has taken it.
    assign w_pop     = (state_q == ST_PRESENT) && !div_BUSY && !flush;
    assign w_head    = mem_q[rd_ptr_q];

    // Write an accepted pair into the slot at the write pointer.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= {req_a, req_b};
        end
    end

    // Pointer and occupancy update; flush empties the queue outright.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (w_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (w_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({w_push, w_pop})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
        end
    end

    // Issue FSM: present head, wait for acceptance, then wait for the divider
    // to go busy so only one pair is handed over per BUSY-low window.
    always_comb begin
        state_d = state_q;
        stb_d   = stb_q;
        a_d     = a_q;
        b_d     = b_q;
        issue_d = issue_q;
        stall_d = stall_q;

        if (stb_q && div_BUSY && (stall_q != C_CNT_MAX)) begin
            stall_d = stall_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if ((level_q != '0) && !flush) begin
                    a_d     = w_head[31:16];
                    b_d     = w_head[15:0];
                    stb_d   = 1'b1;
                    state_d = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                if (flush) begin
                    stb_d   = 1'b0;
                    state_d = ST_IDLE;
                end else if (!div_BUSY) begin
                    stb_d   = 1'b0;
                    issue_d = issue_q + 1'b1;
                    state_d = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                stb_d = 1'b0;
                if (div_BUSY) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                stb_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            a_q      <= '0;
            b_q      <= '0;
            stb_q    <= 1'b0;
            issue_q  <= '0;
            stall_q  <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            a_q      <= a_d;
            b_q      <= b_d;
            stb_q    <= stb_d;
            issue_q  <= issue_d;
            stall_q  <= stall_d;
        end
    end

    assign input_a       = a_q;
    assign input_b       = b_q;
    assign div_input_STB = stb_q;
    assign fifo_level    = level_q;
    assign issue_count   = issue_q;
    assign stall_cycles  = stall_q;
    assign dispatch_idle = (level_q == '0) && (state_q == ST_IDLE);

endmodule
`default_nettype wire
